// File: rtl/vec_instr_issuer.sv
// Vector instruction issuer: encodes field-level requests into RVV (v0.8-style) words,
// queues them and issues one per start pulse. Optional issue counter: VEC_ISSUE_CNT_EN.
module vec_instr_issuer #(
  parameter int DEPTH     = 4,
  parameter int ISSUE_GAP = 2,
  parameter int GAP_W     = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [2:0]  req_alu_op,
  input  logic [4:0]  req_vd,
  input  logic [4:0]  req_vs1,
  input  logic [4:0]  req_vs2,
  input  logic        req_vm,
  input  logic [2:0]  req_vsew,
  input  logic [1:0]  req_vlmul,
  output logic [31:0] vector_instruction,
  output logic        start,
`ifdef VEC_ISSUE_CNT_EN
  output logic [15:0] issued_count,
`endif
  output logic        issue_busy
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [6:0] OPC_OPV   = 7'b1010111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000111;
  localparam logic [6:0] OPC_STORE = 7'b0100111;

  typedef enum logic [1:0] {
    KIND_ALU   = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2,
    KIND_VSET  = 2'd3
  } kind_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Request encoder
  // ---------------------------------------------------------------------------
  logic [5:0]  funct6;
  logic [2:0]  funct3;
  logic [1:0]  sew_lo;
  logic [2:0]  mem_width;
  logic [10:0] zimm;
  logic [31:0] enc_word;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    funct6 = 6'b000000;
    funct3 = 3'b000;
    case (req_alu_op)
      3'd0:    funct6 = 6'b000000;
      3'd1:    funct6 = 6'b000010;
      3'd2:    funct6 = 6'b001001;
      3'd3:    funct6 = 6'b001010;
      3'd4:    funct6 = 6'b001011;
      3'd5:    funct6 = 6'b000100;
      3'd6:    funct6 = 6'b000110;
      default: begin
        funct6 = 6'b100101;
        funct3 = 3'b010;
      end
    endcase
  end

  // SEW codes 4-7 alias onto 0-3.
  always_comb begin
    sew_lo = 2'd0;
    case (req_vsew)
      3'd0, 3'd4: sew_lo = 2'd0;
      3'd1, 3'd5: sew_lo = 2'd1;
      3'd2, 3'd6: sew_lo = 2'd2;
      default:    sew_lo = 2'd3;
    endcase
  end

  always_comb begin
    mem_width = 3'b000;
    case (sew_lo)
      2'd0:    mem_width = 3'b000;
      2'd1:    mem_width = 3'b101;
      2'd2:    mem_width = 3'b110;
      default: mem_width = 3'b111;
    endcase
  end

  assign zimm = {4'b0000, 2'b00, 1'b0, sew_lo, req_vlmul};

  always_comb begin
    enc_word = '0;
    case (kind_e'(req_kind))
      KIND_ALU:
        enc_word = {funct6, req_vm, req_vs2, req_vs1, funct3, req_vd, OPC_OPV};
      KIND_LOAD:
        enc_word = {3'b000, 1'b0, 2'b00, req_vm, 5'b00000, req_vs1, mem_width,
                    req_vd, OPC_LOAD};
      KIND_STORE:
        enc_word = {3'b000, 1'b0, 2'b00, req_vm, 5'b00000, req_vs1, mem_width,
                    req_vd, OPC_STORE};
      default:
        enc_word = {1'b0, zimm, req_vs1, 3'b111, req_vd, OPC_OPV};
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO (extra pointer bit separates full from empty)
  // ---------------------------------------------------------------------------
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]  mem_q [DEPTH];
  logic         fifo_empty;
  logic         fifo_full;
  logic         push;
  logic         pop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign req_ready  = !fifo_full;
  assign push       = req_valid && req_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= enc_word;
  end

  // ---------------------------------------------------------------------------
  // Issue FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [31:0]       instr_q, instr_d;
  logic              start_q, start_d;

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (!fifo_empty && (ISSUE_GAP != 0)) state_d = ST_GAP;
        ST_GAP:  if (gap_cnt_q <= GAP_W'(1))           state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pop       = 1'b0;
    start_d   = 1'b0;
    instr_d   = instr_q;
    gap_cnt_d = gap_cnt_q;
    if (flush) begin
      gap_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            start_d   = 1'b1;
            instr_d   = mem_q[rd_ptr_q[AW-1:0]];
            gap_cnt_d = GAP_W'(ISSUE_GAP);
          end
        end
        ST_GAP:  gap_cnt_d = gap_cnt_q - GAP_W'(1);
        default: gap_cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      gap_cnt_q <= '0;
      instr_q   <= '0;
      start_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      gap_cnt_q <= gap_cnt_d;
      instr_q   <= instr_d;
      start_q   <= start_d;
    end
  end

  assign vector_instruction = instr_q;
  assign start              = start_q;
  assign issue_busy         = !fifo_empty || (state_q == ST_GAP);

`ifdef VEC_ISSUE_CNT_EN
  // Counts start pulses; survives flush, wraps naturally at 16 bits.
  logic [15:0] issued_cnt_q, issued_cnt_d;

  always_comb begin
    issued_cnt_d = issued_cnt_q;
    if (start_d) issued_cnt_d = issued_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) issued_cnt_q <= '0;
    else       issued_cnt_q <= issued_cnt_d;
  end

  assign issued_count = issued_cnt_q;
`endif

endmodule

// File: tb/tb_vec_instr_issuer.sv
// Directed bench for vec_instr_issuer: encodings, latency, gap spacing, back-pressure,
// flush and mid-gap reset. A second instance runs with ISSUE_GAP=0.
module tb_vec_instr_issuer;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        req_valid;
  logic        req_valid0;
  logic [1:0]  req_kind;
  logic [2:0]  req_alu_op;
  logic [4:0]  req_vd;
  logic [4:0]  req_vs1;
  logic [4:0]  req_vs2;
  logic        req_vm;
  logic [2:0]  req_vsew;
  logic [1:0]  req_vlmul;

  logic        req_ready,  req_ready0;
  logic [31:0] vector_instruction, vector_instruction0;
  logic        start, start0;
  logic        issue_busy, issue_busy0;
`ifdef VEC_ISSUE_CNT_EN
  logic [15:0] issued_count, issued_count0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int          log_cyc[$];
  logic [31:0] log_ins[$];
  int          log0_cyc[$];
  logic [31:0] log0_ins[$];

  vec_instr_issuer #(.DEPTH(4), .ISSUE_GAP(2), .GAP_W(4)) dut (
    .clk                (clk),
    .rstn               (rstn),
    .flush              (flush),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_kind           (req_kind),
    .req_alu_op         (req_alu_op),
    .req_vd             (req_vd),
    .req_vs1            (req_vs1),
    .req_vs2            (req_vs2),
    .req_vm             (req_vm),
    .req_vsew           (req_vsew),
    .req_vlmul          (req_vlmul),
    .vector_instruction (vector_instruction),
    .start              (start),
`ifdef VEC_ISSUE_CNT_EN
    .issued_count       (issued_count),
`endif
    .issue_busy         (issue_busy)
  );

  vec_instr_issuer #(.DEPTH(4), .ISSUE_GAP(0), .GAP_W(4)) dut0 (
    .clk                (clk),
    .rstn               (rstn),
    .flush              (1'b0),
    .req_valid          (req_valid0),
    .req_ready          (req_ready0),
    .req_kind           (req_kind),
    .req_alu_op         (req_alu_op),
    .req_vd             (req_vd),
    .req_vs1            (req_vs1),
    .req_vs2            (req_vs2),
    .req_vm             (req_vm),
    .req_vsew           (req_vsew),
    .req_vlmul          (req_vlmul),
    .vector_instruction (vector_instruction0),
    .start              (start0),
`ifdef VEC_ISSUE_CNT_EN
    .issued_count       (issued_count0),
`endif
    .issue_busy         (issue_busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn && start) begin
      log_cyc.push_back(cyc);
      log_ins.push_back(vector_instruction);
    end
    if (rstn && start0) begin
      log0_cyc.push_back(cyc);
      log0_ins.push_back(vector_instruction0);
    end
  end

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  op;
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic        vm;
    logic [2:0]  vsew;
    logic [1:0]  vlmul;
    logic [31:0] exp;
  } vec_t;

  localparam int NUM_VEC = 14;
  vec_t tbl [NUM_VEC];

  initial begin
    //           kind  op    vd     vs1    vs2    vm    vsew  vlmul expected word
    tbl[0]  = '{2'd0, 3'd0, 5'd3,  5'd1,  5'd2,  1'b1, 3'd0, 2'd0, 32'h022081D7}; // vadd
    tbl[1]  = '{2'd1, 3'd0, 5'd4,  5'd5,  5'd0,  1'b1, 3'd2, 2'd0, 32'h0202E207}; // load e32
    tbl[2]  = '{2'd3, 3'd0, 5'd1,  5'd2,  5'd0,  1'b1, 3'd2, 2'd0, 32'h008170D7}; // vsetvli
    tbl[3]  = '{2'd2, 3'd0, 5'd8,  5'd10, 5'd0,  1'b0, 3'd0, 2'd0, 32'h00050427}; // store e8
    tbl[4]  = '{2'd0, 3'd7, 5'd5,  5'd6,  5'd7,  1'b0, 3'd0, 2'd0, 32'h947322D7}; // vmul masked
    tbl[5]  = '{2'd1, 3'd0, 5'd1,  5'd3,  5'd0,  1'b1, 3'd5, 2'd0, 32'h0201D087}; // load sew 5
    tbl[6]  = '{2'd3, 3'd0, 5'd0,  5'd0,  5'd0,  1'b1, 3'd7, 2'd3, 32'h00F07057}; // vsetvli sew 7
    tbl[7]  = '{2'd0, 3'd4, 5'd31, 5'd31, 5'd31, 1'b1, 3'd0, 2'd0, 32'h2FFF8FD7}; // vxor max regs
    tbl[8]  = '{2'd0, 3'd1, 5'd2,  5'd3,  5'd4,  1'b1, 3'd0, 2'd0, 32'h0A418157}; // vsub
    tbl[9]  = '{2'd0, 3'd5, 5'd0,  5'd0,  5'd0,  1'b1, 3'd0, 2'd0, 32'h12000057}; // vminu
    tbl[10] = '{2'd0, 3'd6, 5'd1,  5'd0,  5'd0,  1'b0, 3'd0, 2'd0, 32'h180000D7}; // vmaxu
    tbl[11] = '{2'd0, 3'd2, 5'd0,  5'd0,  5'd1,  1'b1, 3'd0, 2'd0, 32'h26100057}; // vand
    tbl[12] = '{2'd0, 3'd3, 5'd0,  5'd1,  5'd0,  1'b0, 3'd0, 2'd0, 32'h28008057}; // vor
    tbl[13] = '{2'd2, 3'd0, 5'd31, 5'd31, 5'd0,  1'b1, 3'd3, 2'd0, 32'h020FFFA7}; // store e64
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int i);
    req_kind   = tbl[i].kind;
    req_alu_op = tbl[i].op;
    req_vd     = tbl[i].vd;
    req_vs1    = tbl[i].vs1;
    req_vs2    = tbl[i].vs2;
    req_vm     = tbl[i].vm;
    req_vsew   = tbl[i].vsew;
    req_vlmul  = tbl[i].vlmul;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (issue_busy && n < 100) begin
      tick();
      n++;
    end
    tick();
    check("wait_idle", issue_busy, 1'b0);
  endtask

  task automatic clear_logs();
    log_cyc.delete();
    log_ins.delete();
    log0_cyc.delete();
    log0_ins.delete();
  endtask

  task automatic check_spacing(input string tag, input int first, input int n, input int gap);
    check({tag, "_count"}, log_cyc.size(), n);
    for (int k = 0; k < n && k < log_cyc.size(); k++) begin
      check($sformatf("%s_word%0d", tag, k), log_ins[k], tbl[first + k].exp);
      if (k > 0) check($sformatf("%s_gap%0d", tag, k), log_cyc[k] - log_cyc[k-1], gap);
    end
  endtask

  initial begin
    int push_cyc;
    int idx;
    logic [7:0] ready_exp;

    rstn       = 1'b1;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_valid0 = 1'b0;
    set_fields(0);
    #1 rstn = 1'b0;
    repeat (2) tick();

    check("rst_instr", vector_instruction, 32'h0);
    check("rst_start", start, 1'b0);
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy",  issue_busy, 1'b0);
`ifdef VEC_ISSUE_CNT_EN
    check("rst_count", issued_count, 16'd0);
`endif
    rstn = 1'b1;
    tick();

    // First ALU push: exact cycle-by-cycle view of latency and gap.
    set_fields(0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("lat_start_early", start, 1'b0);
    check("lat_busy_queued", issue_busy, 1'b1);
    tick();
    check("lat_start", start, 1'b1);
    check("lat_instr", vector_instruction, 32'h022081D7);
    tick();
    check("gap1_start", start, 1'b0);
    check("gap1_busy",  issue_busy, 1'b1);
    check("gap1_hold",  vector_instruction, 32'h022081D7);
    tick();
    check("gap2_busy",  issue_busy, 1'b0);
    clear_logs();

    // Encoding table, one request at a time.
    for (int i = 0; i < NUM_VEC; i++) begin
      set_fields(i);
      req_valid = 1'b1;
      tick();
      push_cyc  = cyc;
      req_valid = 1'b0;
      wait_idle();
      check($sformatf("enc%0d_count", i), log_cyc.size(), 1);
      if (log_cyc.size() > 0) begin
        check($sformatf("enc%0d_word", i), log_ins[0], tbl[i].exp);
        check($sformatf("enc%0d_lat", i), log_cyc[0] - push_cyc, 1);
      end
      clear_logs();
    end

    // Back-to-back pushes: pulses 1+ISSUE_GAP apart, in order.
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_fields(i);
      tick();
    end
    req_valid = 1'b0;
    wait_idle();
    check_spacing("b2b", 0, 3, 3);
    clear_logs();

    // Same with ISSUE_GAP=0 instance: consecutive pulses.
    req_valid0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_fields(i + 3);
      tick();
    end
    req_valid0 = 1'b0;
    repeat (6) tick();
    check("gap0_count", log0_cyc.size(), 3);
    for (int k = 0; k < 3 && k < log0_cyc.size(); k++) begin
      check($sformatf("gap0_word%0d", k), log0_ins[k], tbl[k + 3].exp);
      if (k > 0) check($sformatf("gap0_gap%0d", k), log0_cyc[k] - log0_cyc[k-1], 1);
    end
    clear_logs();

    // Fill to full while the issuer sits in its gap; ready per edge hand-derived.
    ready_exp = 8'b0011_1111;  // bit k: ready before edge k
    idx = 0;
    req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_fields(idx);
      check($sformatf("fill_ready%0d", k), req_ready, ready_exp[k]);
      tick();
      if (ready_exp[k]) idx++;
    end
    req_valid = 1'b0;
    check("fill_ready_after_pop", req_ready, 1'b1);
    wait_idle();
    check_spacing("fill", 0, 6, 3);
    clear_logs();

    // Flush with three entries queued and a concurrent push.
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_fields(i);
      tick();
    end
    set_fields(4);
    flush = 1'b1;
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    check("flush_start", start, 1'b0);
    check("flush_busy",  issue_busy, 1'b0);
    check("flush_ready", req_ready, 1'b1);
    check("flush_hold",  vector_instruction, tbl[0].exp);
    repeat (8) tick();
    check("flush_starts", log_cyc.size(), 1);
`ifdef VEC_ISSUE_CNT_EN
    check("flush_count", issued_count, 16'(NUM_VEC + 1 + 3 + 6 + 1));
`endif
    clear_logs();

    // Reset mid-gap with two entries queued.
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_fields(i);
      tick();
    end
    req_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check("mrst_instr", vector_instruction, 32'h0);
    check("mrst_start", start, 1'b0);
    check("mrst_busy",  issue_busy, 1'b0);
    check("mrst_ready", req_ready, 1'b1);
`ifdef VEC_ISSUE_CNT_EN
    check("mrst_count", issued_count, 16'd0);
`endif
    repeat (2) tick();
    rstn = 1'b1;
    repeat (8) tick();
    check("mrst_no_start", log_cyc.size(), 1);
    clear_logs();

    set_fields(3);
    req_valid = 1'b1;
    tick();
    push_cyc  = cyc;
    req_valid = 1'b0;
    wait_idle();
    check("post_rst_count", log_cyc.size(), 1);
    if (log_cyc.size() > 0) begin
      check("post_rst_word", log_ins[0], tbl[3].exp);
      check("post_rst_lat",  log_cyc[0] - push_cyc, 1);
    end
`ifdef VEC_ISSUE_CNT_EN
    check("post_rst_issued", issued_count, 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
